// File: rtl/gmii_frame_tx.sv
// rtl/gmii_frame_tx.sv - GMII transmit framer: IFG, preamble/SFD, padding, CRC-32 FCS, underrun abort
module gmii_frame_tx #(
    parameter int IFG_BYTES      = 12,
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_FRAME      = 60,
    parameter int APPEND_FCS     = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic             gmii_txctrl,
    output logic [7:0]       gmii_txdata,
    output logic             busy,
    output logic             underrun,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DROP} state_t;

    localparam logic [3:0]       PRE_LAST = 4'(PREAMBLE_BYTES - 1);
    localparam logic [7:0]       IFG_LAST = 8'(IFG_BYTES - 1);
    localparam logic [11:0]      MIN_LEN  = 12'(MIN_FRAME);
    localparam logic [10:0]      LEN_MAX  = 11'h7FF;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_n;
    logic [3:0]       pcnt, pcnt_n;
    logic [7:0]       gcnt, gcnt_n;
    logic [10:0]      len, len_n, len_inc;
    logic [31:0]      crc, crc_n, fcs_word;
    logic [1:0]       fidx, fidx_n;
    logic [CNT_W-1:0] cnt_n;
    logic             txctrl_n, underrun_n, ready_n, busy_n;
    logic [7:0]       txdata_n;
    state_t           tail;

    // Reflected CRC-32, one byte LSB-first
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign len_inc  = (len == LEN_MAX) ? len : len + 11'd1;
    assign fcs_word = ~crc;

    // Where a frame goes once the byte now being emitted brings the length to len_inc
    always_comb begin
        tail = IFG;
        if ({1'b0, len_inc} < MIN_LEN) begin
            tail = PAD;
        end else if (APPEND_FCS != 0) begin
            tail = FCS;
        end
    end

    always_comb begin
        state_n    = state;
        pcnt_n     = 4'd0;
        gcnt_n     = 8'd0;
        fidx_n     = 2'd0;
        len_n      = len;
        crc_n      = crc;
        cnt_n      = frame_cnt;
        txctrl_n   = 1'b0;
        txdata_n   = 8'h00;
        underrun_n = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    txctrl_n = 1'b1;
                    txdata_n = 8'h55;
                    pcnt_n   = 4'd1;
                    state_n  = (PRE_LAST == 4'd0) ? SFD : PRE;
                end
            end
            PRE: begin
                txctrl_n = 1'b1;
                txdata_n = 8'h55;
                pcnt_n   = pcnt + 4'd1;
                if (pcnt == PRE_LAST) begin
                    state_n = SFD;
                end
            end
            SFD: begin
                txctrl_n = 1'b1;
                txdata_n = 8'hD5;
                crc_n    = 32'hFFFFFFFF;
                len_n    = 11'd0;
                state_n  = DATA;
            end
            DATA: begin
                if (s_valid) begin
                    txctrl_n = 1'b1;
                    txdata_n = s_data;
                    crc_n    = crc_byte(crc, s_data);
                    len_n    = len_inc;
                    if (s_last) begin
                        state_n = tail;
                    end
                end else begin
                    underrun_n = 1'b1;
                    state_n    = DROP;
                end
            end
            PAD: begin
                txctrl_n = 1'b1;
                crc_n    = crc_byte(crc, 8'h00);
                len_n    = len_inc;
                state_n  = tail;
            end
            FCS: begin
                txctrl_n = 1'b1;
                case (fidx)
                    2'd0:    txdata_n = fcs_word[7:0];
                    2'd1:    txdata_n = fcs_word[15:8];
                    2'd2:    txdata_n = fcs_word[23:16];
                    default: txdata_n = fcs_word[31:24];
                endcase
                fidx_n = fidx + 2'd1;
                if (fidx == 2'd3) begin
                    state_n = IFG;
                end
            end
            IFG: begin
                gcnt_n = gcnt + 8'd1;
                if (gcnt == IFG_LAST) begin
                    state_n = IDLE;
                end
            end
            DROP: begin
                if (s_valid && s_last) begin
                    state_n = IFG;
                end
            end
            default: state_n = IDLE;
        endcase
        // Entering the gap from anywhere but DROP means the frame went out whole
        if (state_n == IFG && state != IFG && state != DROP) begin
            cnt_n = frame_cnt + CNT_ONE;
        end
        ready_n = (state_n == DATA) || (state_n == DROP);
        busy_n  = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pcnt        <= 4'd0;
            gcnt        <= 8'd0;
            fidx        <= 2'd0;
            len         <= 11'd0;
            crc         <= 32'hFFFFFFFF;
            frame_cnt   <= '0;
            gmii_txctrl <= 1'b0;
            gmii_txdata <= 8'h00;
            underrun    <= 1'b0;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            pcnt        <= pcnt_n;
            gcnt        <= gcnt_n;
            fidx        <= fidx_n;
            len         <= len_n;
            crc         <= crc_n;
            frame_cnt   <= cnt_n;
            gmii_txctrl <= txctrl_n;
            gmii_txdata <= txdata_n;
            underrun    <= underrun_n;
            s_ready     <= ready_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// tb/tb_gmii_frame_tx.sv - self-checking bench for gmii_frame_tx (three parameter sets)
module tb_gmii_frame_tx;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [7:0] b;
        bit         last;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #4 clk = ~clk;

    logic       sv [3];
    logic       sl [3];
    logic [7:0] sd [3];

    logic        r0, c0, b0, u0, r1, c1, b1, u1, r2, c2, b2, u2;
    logic [7:0]  d0, d1, d2;
    logic [15:0] fc0, fc1, fc2;

    gmii_frame_tx dut0 (
        .clk(clk), .rst(rst), .s_data(sd[0]), .s_valid(sv[0]), .s_last(sl[0]), .s_ready(r0),
        .gmii_txctrl(c0), .gmii_txdata(d0), .busy(b0), .underrun(u0), .frame_cnt(fc0)
    );
    gmii_frame_tx #(.MIN_FRAME(0)) dut1 (
        .clk(clk), .rst(rst), .s_data(sd[1]), .s_valid(sv[1]), .s_last(sl[1]), .s_ready(r1),
        .gmii_txctrl(c1), .gmii_txdata(d1), .busy(b1), .underrun(u1), .frame_cnt(fc1)
    );
    gmii_frame_tx #(.PREAMBLE_BYTES(3), .IFG_BYTES(1), .MIN_FRAME(0), .APPEND_FCS(0)) dut2 (
        .clk(clk), .rst(rst), .s_data(sd[2]), .s_valid(sv[2]), .s_last(sl[2]), .s_ready(r2),
        .gmii_txctrl(c2), .gmii_txdata(d2), .busy(b2), .underrun(u2), .frame_cnt(fc2)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    ent_t exp_q [$];
    int   start_cyc [3];
    int   last_gap [3];
    int   flen [3];
    int   last_len [3];
    int   idle_run [3];
    int   ucount [3];
    bit   mid [3];
    bit   gap_rdy [3];
    bit   gap_rdy_snap [3];
    bit   prev_c [3];
    int   v_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_fcs(input bq_t q);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[k]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ q[k][b]) c = (c >> 1) ^ 32'hEDB88320;
                else                c = c >> 1;
            end
        end
        return ~c;
    endfunction

    // Whole wire image of one frame; cut >= 0 keeps only that many payload bytes (aborted frame)
    function automatic bq_t frame_bytes(input int pre, input bit fcs, input int minf,
                                        input bq_t pay, input int cut);
        bq_t w;
        bq_t f;
        logic [31:0] x;
        for (int k = 0; k < pre; k++) w.push_back(8'h55);
        w.push_back(8'hD5);
        if (cut >= 0) begin
            for (int k = 0; k < cut; k++) w.push_back(pay[k]);
            return w;
        end
        f = pay;
        while (f.size() < minf) f.push_back(8'h00);
        foreach (f[k]) w.push_back(f[k]);
        if (fcs) begin
            x = model_fcs(f);
            for (int k = 0; k < 4; k++) w.push_back(x[8*k +: 8]);
        end
        return w;
    endfunction

    task automatic expect_bytes(input bq_t w);
        foreach (w[k]) exp_q.push_back('{b: w[k], last: (k == w.size() - 1)});
    endtask

    function automatic bq_t mk(input int n, input int seed);
        bq_t q;
        for (int k = 0; k < n; k++) q.push_back(8'((k * 13 + seed) & 255));
        return q;
    endfunction

    function automatic logic rdy(input int i);
        case (i)
            0:       return r0;
            1:       return r1;
            default: return r2;
        endcase
    endfunction

    task automatic send(input int inst, input bq_t pay, input int cut_at, output int last_acc);
        int idx;
        int tmo;
        bit acc;
        idx = 0;
        tmo = 0;
        last_acc = 0;
        v_cyc = cyc;
        sv[inst] = 1'b1;
        sd[inst] = pay[0];
        sl[inst] = (pay.size() == 1);
        while (idx < pay.size()) begin
            @(negedge clk);
            acc = rdy(inst);
            if (acc) last_acc = cyc + 1;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx == cut_at) begin
                    sv[inst] = 1'b0;
                    @(posedge clk);
                    #1;
                end
                if (idx < pay.size()) begin
                    sv[inst] = 1'b1;
                    sd[inst] = pay[idx];
                    sl[inst] = (idx == pay.size() - 1);
                end else begin
                    sv[inst] = 1'b0;
                    sl[inst] = 1'b0;
                    sd[inst] = 8'h00;
                end
            end else begin
                tmo++;
                if (tmo > 400) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout inst=%0d actual=stalled required=accepted", inst);
                    break;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Pin monitor: every txctrl=1 byte is popped from the model queue, idle cycles must be 0x00
    initial begin
        logic       oc [3];
        logic       ob [3];
        logic       ou [3];
        logic       orr [3];
        logic [7:0] od [3];
        ent_t       e;
        forever begin
            @(negedge clk);
            oc[0] = c0;  oc[1] = c1;  oc[2] = c2;
            ob[0] = b0;  ob[1] = b1;  ob[2] = b2;
            ou[0] = u0;  ou[1] = u1;  ou[2] = u2;
            orr[0] = r0; orr[1] = r1; orr[2] = r2;
            od[0] = d0;  od[1] = d1;  od[2] = d2;
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    mid[i] = 1'b0;
                    idle_run[i] = 0;
                    gap_rdy[i] = 1'b0;
                    prev_c[i] = 1'b0;
                end else begin
                    if (oc[i]) begin
                        if (!mid[i]) begin
                            start_cyc[i] = cyc;
                            last_gap[i] = idle_run[i];
                            gap_rdy_snap[i] = gap_rdy[i];
                            flen[i] = 0;
                            mid[i] = 1'b1;
                        end
                        flen[i]++;
                        chk("busy_in_frame", 64'(ob[i]), 64'd1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_byte inst=%0d actual=%0h required=no_txctrl", i, od[i]);
                        end else begin
                            e = exp_q.pop_front();
                            chk("txdata", 64'(od[i]), 64'(e.b));
                            if (e.last) begin
                                mid[i] = 1'b0;
                                last_len[i] = flen[i];
                                idle_run[i] = 0;
                                gap_rdy[i] = 1'b0;
                            end
                        end
                    end else begin
                        if (mid[i]) begin
                            checks++;
                            errors++;
                            $display("FAIL txctrl_contiguous inst=%0d actual=0 required=1", i);
                            mid[i] = 1'b0;
                        end
                        chk("idle_data", 64'(od[i]), 64'd0);
                        idle_run[i]++;
                        if (orr[i]) gap_rdy[i] = 1'b1;
                    end
                    if (ou[i]) begin
                        ucount[i]++;
                        chk("underrun_edge", 64'({prev_c[i], oc[i]}), 64'b10);
                    end
                    prev_c[i] = oc[i];
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t w;
        bq_t p1;
        bq_t pa;
        bq_t pb;
        int  acc;
        int  acc_abort;
        int  u_before;
        logic [15:0] fc_before;
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b0; sl[i] = 1'b0; sd[i] = 8'h00;
            ucount[i] = 0; mid[i] = 1'b0; idle_run[i] = 0;
        end
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txctrl", 64'(c0), 64'd0);
        chk("rst_txdata", 64'(d0), 64'd0);
        chk("rst_ready",  64'(r0), 64'd0);
        chk("rst_busy",   64'(b0), 64'd0);
        chk("rst_underrun", 64'(u0), 64'd0);
        chk("rst_frame_cnt", 64'(fc0), 64'd0);
        chk("rst_txctrl_dut2", 64'(c2), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: "123456789" with FCS and no padding
        p1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model_crc_check", 64'(model_fcs(p1)), 64'hCBF43926);
        w = frame_bytes(7, 1'b1, 0, p1, -1);
        chk("model_t1_size", 64'(w.size()), 64'd21);
        chk("model_t1_fcs_bytes", 64'({w[17], w[18], w[19], w[20]}), 64'h2639F4CB);
        expect_bytes(w);
        send(1, p1, -1, acc);
        repeat (30) @(posedge clk);
        #1;
        chk("t1_start_latency", 64'(start_cyc[1] - v_cyc), 64'd1);
        chk("t1_txctrl_len", 64'(last_len[1]), 64'd21);
        chk("t1_frame_cnt", 64'(fc1), 64'd1);

        // 2: 10-byte payload padded to 60
        pa = mk(10, 5);
        w = frame_bytes(7, 1'b1, 60, pa, -1);
        chk("model_t2_size", 64'(w.size()), 64'd72);
        chk("model_t2_pad", 64'({w[18], w[67]}), 64'h0);
        expect_bytes(w);
        send(0, pa, -1, acc);
        repeat (80) @(posedge clk);
        #1;
        chk("t2_txctrl_len", 64'(last_len[0]), 64'd72);
        chk("t2_frame_cnt", 64'(fc0), 64'd1);

        // 3: back-to-back, s_valid held high
        pa = mk(60, 9);
        pb = mk(12, 77);
        expect_bytes(frame_bytes(7, 1'b1, 60, pa, -1));
        expect_bytes(frame_bytes(7, 1'b1, 60, pb, -1));
        send(0, pa, -1, acc);
        send(0, pb, -1, acc);
        repeat (90) @(posedge clk);
        #1;
        chk("t3_ifg_gap", 64'(last_gap[0]), 64'd12);
        chk("t3_ready_in_gap", 64'(gap_rdy_snap[0]), 64'd0);
        chk("t3_frame_cnt", 64'(fc0), 64'd3);

        // 4: underrun after 20 of 64 bytes, then a clean frame
        u_before = ucount[0];
        fc_before = fc0;
        pa = mk(64, 21);
        pb = mk(15, 40);
        expect_bytes(frame_bytes(7, 1'b1, 60, pa, 20));
        expect_bytes(frame_bytes(7, 1'b1, 60, pb, -1));
        send(0, pa, 20, acc_abort);
        chk("t4_cnt_after_abort", 64'(fc0), 64'(fc_before));
        chk("t4_underrun_pulses", 64'(ucount[0] - u_before), 64'd1);
        send(0, pb, -1, acc);
        repeat (90) @(posedge clk);
        #1;
        chk("t4_gap_after_drop", 64'(start_cyc[0] - acc_abort), 64'd13);
        chk("t4_next_len", 64'(last_len[0]), 64'd72);
        chk("t4_frame_cnt", 64'(fc0), 64'(fc_before + 16'd1));

        // 5: 3-byte preamble, 1-byte gap, no FCS, 1-byte frames
        pa = '{8'hAB};
        pb = '{8'hCD};
        w = frame_bytes(3, 1'b0, 0, pa, -1);
        chk("model_t5_bytes", 64'({w[0], w[1], w[2], w[3], w[4]}), 64'h555555D5AB);
        expect_bytes(w);
        expect_bytes(frame_bytes(3, 1'b0, 0, pb, -1));
        send(2, pa, -1, acc);
        send(2, pb, -1, acc);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_txctrl_len", 64'(last_len[2]), 64'd5);
        chk("t5_gap", 64'(last_gap[2]), 64'd1);
        chk("t5_frame_cnt", 64'(fc2), 64'd2);

        // 6: reset during FCS, then a clean restart
        pa = mk(60, 3);
        expect_bytes(frame_bytes(7, 1'b1, 60, pa, -1));
        send(0, pa, -1, acc);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_txctrl", 64'(c0), 64'd0);
        chk("t6_txdata", 64'(d0), 64'd0);
        chk("t6_busy", 64'(b0), 64'd0);
        chk("t6_ready", 64'(r0), 64'd0);
        chk("t6_frame_cnt", 64'(fc0), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_cnt_after_release", 64'(fc0), 64'd0);
        pb = mk(5, 99);
        expect_bytes(frame_bytes(7, 1'b1, 60, pb, -1));
        send(0, pb, -1, acc);
        repeat (80) @(posedge clk);
        #1;
        chk("t6_start_latency", 64'(start_cyc[0] - v_cyc), 64'd1);
        chk("t6_txctrl_len", 64'(last_len[0]), 64'd72);
        chk("t6_frame_cnt_new", 64'(fc0), 64'd1);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("no_underrun_dut1", 64'(ucount[1]), 64'd0);
        chk("no_underrun_dut2", 64'(ucount[2]), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
